// File: rtl/wb_dmem_pkg.sv
// Shared types and widths for the Wishbone data-memory slave and its byte-lane RAM.
package wb_dmem_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;
   localparam int WB_ADDR_W = 32;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // One captured bus request; held from the sample cycle through the response.
   typedef struct packed {
      logic                 we;
      logic [WB_SEL_W-1:0]  sel;
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word memory built from four byte-wide banks: per-lane synchronous write, combinational read.
module dmem_byte_ram
   import wb_dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WB_SEL_W-1:0]   we,
   input  logic [WB_DATA_W-1:0]  wdata,
   output logic [WB_DATA_W-1:0]  rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   for (genvar lane = 0; lane < WB_SEL_W; lane++) begin : g_lane
      logic [7:0] bank [DEPTH];

      // NOTE: storage arrays get no reset; clearing them would force flops instead of RAM.
      always_ff @(posedge clk) begin
         if (we[lane]) begin
            bank[addr] <= wdata[8*lane +: 8];
         end
      end

      assign rdata[8*lane +: 8] = bank[addr];
   end

endmodule

// File: rtl/wb_dmem_slave.sv
// Wishbone B3 classic data-memory slave with programmable wait states and byte-lane writes.
// Define DMEM_ERR_EN to terminate misaligned or out-of-window accesses with wb_err_o.
module wb_dmem_slave
   import wb_dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [WB_SEL_W-1:0]  wb_sel_i,
   input  logic [WB_ADDR_W-1:0] wb_addr_i,
   input  logic [WB_DATA_W-1:0] wb_data_i,
   output logic [WB_DATA_W-1:0] wb_data_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o
);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   req_t                 bus_req;
   req_t                 lat;
   req_t                 cur;
   logic [WB_ADDR_W-1:0] offset;
   logic [ADDR_WIDTH-1:0] idx;
   logic                 cur_err;
   logic                 enter_resp;
   logic                 ack_q;
   logic [WB_DATA_W-1:0] data_q;
   logic [WB_SEL_W-1:0]  ram_we;
   logic [WB_DATA_W-1:0] ram_rdata;

   always_comb begin
      bus_req.we   = wb_we_i;
      bus_req.sel  = wb_sel_i;
      bus_req.addr = wb_addr_i;
      bus_req.data = wb_data_i;
   end

   // In IDLE the live bus is the request being sampled; afterwards only the latched copy counts.
   assign cur    = (state == IDLE) ? bus_req : lat;
   assign offset = cur.addr - BASE_ADDR;
   assign idx    = offset[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_EN
   logic err_q;

   assign cur_err  = (offset[1:0] != 2'b00) || (offset[WB_ADDR_W-1:ADDR_WIDTH+2] != '0);
   assign wb_err_o = err_q;
`else
   logic unused_offset_bits;

   assign cur_err            = 1'b0;
   assign unused_offset_bits = ^{offset[WB_ADDR_W-1:ADDR_WIDTH+2], offset[1:0]};
   assign wb_err_o           = 1'b0;
`endif

   // NOTE: always_comb assigns a default first so no path leaves enter_resp unassigned (no latch).
   always_comb begin
      enter_resp = 1'b0;
      unique case (state)
         IDLE:    enter_resp = wb_cyc_i && wb_stb_i && (WAIT_STATES == 0);
         WAIT:    enter_resp = wb_cyc_i && (cnt == CNT_W'(1));
         default: enter_resp = 1'b0;
      endcase
   end

   // ack_q is high only in a good RESP, where cur is the latched request.
   assign ram_we = (ack_q && lat.we) ? lat.sel : '0;

   dmem_byte_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .addr  (idx),
      .we    (ram_we),
      .wdata (lat.data),
      .rdata (ram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         lat    <= '0;
         ack_q  <= 1'b0;
         data_q <= '0;
`ifdef DMEM_ERR_EN
         err_q  <= 1'b0;
`endif
      end else begin
         ack_q <= enter_resp && !cur_err;
`ifdef DMEM_ERR_EN
         err_q <= enter_resp && cur_err;
`endif
         if (enter_resp && !cur_err && !cur.we) begin
            data_q <= ram_rdata;
         end

         case (state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  lat   <= bus_req;
                  cnt   <= CNT_W'(WAIT_STATES);
                  state <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (!wb_cyc_i) begin
                  state <= IDLE;
               end else if (cnt == CNT_W'(1)) begin
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_data_o = data_q;

endmodule
